// File: rtl/clint_timer_if.sv
// rtl/clint_timer_if.sv - request/response bus between the MEM-stage initiator and the CLINT timer
interface clint_timer_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_wstrb_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );
endinterface

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - core-local timer and software-interrupt responder (msip, mtimecmp, mtime)
module clint_timer #(
    parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
    parameter int          TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    clint_timer_if.slave bus,
    output logic        mtip_o,
    output logic        msip_o
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [12:0] IDX_MSIP     = 13'h0000;
    localparam logic [12:0] IDX_MTIMECMP = 13'h0800;
    localparam logic [12:0] IDX_MTIME    = 13'h17FF;

    typedef enum logic {IDLE, RESP} state_t;

    state_t        state, state_next;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          msip;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [63:0]   resp_rdata;
    logic          resp_err;

    logic          accept;
    logic [60:0]   word_off;
    logic          in_window;
    logic          sel_msip, sel_cmp, sel_time, mapped;
    logic [63:0]   rd_data;
    logic          unused_addr_bits;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  strb);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return r;
    endfunction

    // Work on doubleword offsets; an address below BASE wraps to a huge offset and falls outside.
    assign unused_addr_bits = ^bus.req_addr_i[2:0];
    assign word_off  = bus.req_addr_i[63:3] - BASE[63:3];
    assign in_window = (word_off[60:13] == '0);
    assign sel_msip  = in_window && (word_off[12:0] == IDX_MSIP);
    assign sel_cmp   = in_window && (word_off[12:0] == IDX_MTIMECMP);
    assign sel_time  = in_window && (word_off[12:0] == IDX_MTIME);
    assign mapped    = sel_msip || sel_cmp || sel_time;

    assign accept = (state == IDLE) && bus.req_valid_i;

    always_comb begin
        rd_data = '0;
        if (sel_msip)      rd_data = {63'd0, msip};
        else if (sel_cmp)  rd_data = mtimecmp;
        else if (sel_time) rd_data = mtime;
    end

    always_comb begin
        state_next       = state;
        bus.req_ready_o  = 1'b0;
        bus.resp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) state_next = RESP;
            end
            RESP: begin
                bus.resp_valid_o = 1'b1;
                if (bus.resp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    assign tick = (tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) tick_cnt <= '0;
        else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    // A store to mtime wins over a same-edge tick; unwritten bytes hold without incrementing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtime <= '0;
        end else if (accept && bus.req_write_i && sel_time) begin
            mtime <= merge_bytes(mtime, bus.req_wdata_i, bus.req_wstrb_i);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else if (accept && bus.req_write_i) begin
            if (sel_cmp)
                mtimecmp <= merge_bytes(mtimecmp, bus.req_wdata_i, bus.req_wstrb_i);
            if (sel_msip && bus.req_wstrb_i[0])
                msip <= bus.req_wdata_i[0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) mtip_o <= 1'b0;
        else       mtip_o <= (mtime >= mtimecmp);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_err   <= !mapped;
            resp_rdata <= (bus.req_write_i || !mapped) ? 64'd0 : rd_data;
        end
    end

    assign bus.resp_rdata_o = resp_rdata;
    assign bus.resp_err_o   = resp_err;
    assign msip_o           = msip;
endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - directed self-checking bench for clint_timer
module tb_clint_timer;
    localparam logic [63:0] BASE  = 64'h0000_0000_0200_0000;
    localparam logic [63:0] A_MSIP = BASE;
    localparam logic [63:0] A_CMP  = BASE + 64'h4000;
    localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mtip, msip;

    clint_timer_if bus();

    clint_timer #(.BASE(BASE), .TICK_DIV(1)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .mtip_o (mtip),
        .msip_o (msip)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    logic [63:0] acc_rdata;
    logic        acc_err, acc_valid, acc_mtip, acc_msip;
    logic        post_mtip, post_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle: accept on the next posedge, handshake on the one after.
    task automatic xfer(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] strb);
        bus.req_valid_i  = 1'b1;
        bus.req_write_i  = wr;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        bus.req_wstrb_i  = strb;
        bus.resp_ready_i = 1'b0;
        @(posedge clock);
        @(negedge clock);
        acc_valid = bus.resp_valid_o;
        acc_rdata = bus.resp_rdata_o;
        acc_err   = bus.resp_err_o;
        acc_mtip  = mtip;
        acc_msip  = msip;
        bus.req_valid_i  = 1'b0;
        bus.resp_ready_i = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.resp_ready_i = 1'b0;
        post_mtip  = mtip;
        post_valid = bus.resp_valid_o;
        chk("xfer_resp_valid", {63'd0, acc_valid}, 64'd1);
        chk("xfer_resp_drop", {63'd0, post_valid}, 64'd0);
    endtask

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_write_i  = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;
        bus.req_wstrb_i  = '0;
        bus.resp_ready_i = 1'b0;

        repeat (2) @(negedge clock);
        chk("rst_req_ready", {63'd0, bus.req_ready_o}, 64'd1);
        chk("rst_resp_valid", {63'd0, bus.resp_valid_o}, 64'd0);
        chk("rst_rdata", bus.resp_rdata_o, 64'd0);
        chk("rst_err", {63'd0, bus.resp_err_o}, 64'd0);
        chk("rst_mtip", {63'd0, mtip}, 64'd0);
        chk("rst_msip", {63'd0, msip}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_mtip", {63'd0, mtip}, 64'd0);
            chk("idle_msip", {63'd0, msip}, 64'd0);
        end
        xfer(1'b0, A_TIME, 64'd0, 8'h00);
        chk("mtime_after_10", acc_rdata, 64'd10);
        chk("mtime_load_err", {63'd0, acc_err}, 64'd0);

        // mtime is 12 here; reach 15 then arm mtimecmp=20.
        repeat (3) @(negedge clock);
        xfer(1'b1, A_CMP, 64'd20, 8'hFF);
        chk("store_rdata_zero", acc_rdata, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("mtip_before_20", {63'd0, mtip}, 64'd0);
        end
        @(negedge clock);
        chk("mtip_rise", {63'd0, mtip}, 64'd1);
        xfer(1'b1, A_CMP, ONES, 8'hFF);
        chk("mtip_lag_on_write", {63'd0, acc_mtip}, 64'd1);
        chk("mtip_fall", {63'd0, post_mtip}, 64'd0);

        // Backpressure: mtime is 23; load is accepted, a second request waits behind it.
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = A_TIME;
        bus.req_wstrb_i = 8'h00;
        @(posedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus.req_addr_i = A_CMP;
            chk("stall_valid", {63'd0, bus.resp_valid_o}, 64'd1);
            chk("stall_rdata", bus.resp_rdata_o, 64'd23);
            chk("stall_req_ready", {63'd0, bus.req_ready_o}, 64'd0);
        end
        bus.resp_ready_i = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.resp_ready_i = 1'b0;
        chk("hs_idle_ready", {63'd0, bus.req_ready_o}, 64'd1);
        chk("hs_idle_valid", {63'd0, bus.resp_valid_o}, 64'd0);
        @(posedge clock);
        @(negedge clock);
        bus.req_valid_i = 1'b0;
        chk("second_valid", {63'd0, bus.resp_valid_o}, 64'd1);
        chk("second_rdata", bus.resp_rdata_o, ONES);
        bus.resp_ready_i = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.resp_ready_i = 1'b0;

        // mtime=4 at accept, 5 after handshake; upper-word store on the next tick edge.
        xfer(1'b1, A_TIME, 64'd4, 8'hFF);
        xfer(1'b1, A_TIME, 64'hAAAA_BBBB_0000_0000, 8'hF0);
        xfer(1'b0, A_TIME, 64'd0, 8'h00);
        chk("mtime_upper_write", acc_rdata, 64'hAAAA_BBBB_0000_0006);

        xfer(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
        xfer(1'b0, A_TIME, 64'd0, 8'h00);
        chk("mtime_max", acc_rdata, ONES);
        xfer(1'b0, A_TIME, 64'd0, 8'h00);
        chk("mtime_wrap", acc_rdata, 64'd1);

        xfer(1'b0, BASE + 64'h1000, 64'd0, 8'h00);
        chk("unmapped_err", {63'd0, acc_err}, 64'd1);
        chk("unmapped_rdata", acc_rdata, 64'd0);
        xfer(1'b1, BASE + 64'h1_4000, 64'd0, 8'hFF);
        chk("outside_err", {63'd0, acc_err}, 64'd1);
        xfer(1'b1, BASE - 64'h8, 64'd0, 8'hFF);
        chk("below_err", {63'd0, acc_err}, 64'd1);
        xfer(1'b0, A_CMP, 64'd0, 8'h00);
        chk("cmp_unchanged", acc_rdata, ONES);
        chk("cmp_load_err", {63'd0, acc_err}, 64'd0);

        xfer(1'b1, A_CMP + 64'h4, 64'h1234_5678_0000_0000, 8'hF0);
        xfer(1'b0, A_CMP, 64'd0, 8'h00);
        chk("cmp_upper_word", acc_rdata, 64'h1234_5678_FFFF_FFFF);

        xfer(1'b1, A_MSIP, ONES, 8'hFF);
        chk("msip_set_next", {63'd0, acc_msip}, 64'd1);
        xfer(1'b0, A_MSIP, 64'd0, 8'h00);
        chk("msip_readback", acc_rdata, 64'd1);
        xfer(1'b1, A_MSIP, 64'd0, 8'h01);
        chk("msip_clear", {63'd0, acc_msip}, 64'd0);

        // Reset while a msip=1 store response is pending.
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b1;
        bus.req_addr_i  = A_MSIP;
        bus.req_wdata_i = 64'd1;
        bus.req_wstrb_i = 8'h01;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid_i = 1'b0;
        chk("pre_rst_msip", {63'd0, msip}, 64'd1);
        chk("pre_rst_valid", {63'd0, bus.resp_valid_o}, 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, bus.resp_valid_o}, 64'd0);
        chk("mid_rst_msip", {63'd0, msip}, 64'd0);
        chk("mid_rst_ready", {63'd0, bus.req_ready_o}, 64'd1);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_no_resp", {63'd0, bus.resp_valid_o}, 64'd0);
        end
        xfer(1'b0, A_CMP, 64'd0, 8'h00);
        chk("post_rst_cmp", acc_rdata, ONES);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/clint_timer.md
# clint_timer

Memory-mapped core-local timer/software-interrupt responder for the rv64IM pipeline. The MEM stage acts as initiator and issues load/store requests; this block services requests that fall in its address window. It holds `msip`, `mtimecmp` and a free-running `mtime`, and drives the machine timer and software interrupt lines toward the CSR file.

## Interface
Parameters:
- `BASE`, `64'h0000_0000_0200_0000`, base address of the 64 KiB window
- `TICK_DIV`, `1`, clock cycles per `mtime` increment (≥1)

Ports:
- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `req_valid_i` in 1: request present
- `req_ready_o` out 1: block can accept a request
- `req_write_i` in 1: 1 = store, 0 = load
- `req_addr_i` in 64: byte address; `addr[2:0]` ignored
- `req_wdata_i` in 64: store data, lane-aligned
- `req_wstrb_i` in 8: byte write enables
- `resp_valid_o` out 1: response present
- `resp_ready_i` in 1: initiator accepts response
- `resp_rdata_o` out 64: load data (0 for stores)
- `resp_err_o` out 1: unmapped offset or address outside window
- `mtip_o` out 1: machine timer interrupt pending
- `msip_o` out 1: machine software interrupt pending

## Operation
- Register map, offset = `addr - BASE`:
  - `0x0000`: `msip`; only bit 0 is implemented
  - `0x4000`: `mtimecmp`, 64-bit
  - `0xBFF8`: `mtime`, 64-bit
- Any other offset, or an address outside `[BASE, BASE+0xFFFF]`: the response has `resp_err_o=1` and `rdata=0`, and writes are dropped.
- FSM has two states:
  - `IDLE`: `req_ready_o=1`. When `req_valid_i` is high, the request is accepted and the FSM moves to `RESP`.
  - `RESP`: `req_ready_o=0`. The FSM holds `resp_valid_o`, `resp_rdata_o` and `resp_err_o` stable until `resp_valid_o & resp_ready_i`, then returns to `IDLE`.
  - There is no bypass. Throughput is at most one request per 2 cycles.
- Writes take effect on the accept edge, per byte lane of `req_wstrb_i`. A 32-bit store to the upper word uses `wstrb[7:4]`.
- Reads return the register value present during the accept cycle, before any same-edge increment. For 32-bit loads the initiator selects the half.
- Tick counter:
  - Counts 0..`TICK_DIV`-1. `mtime` increments by 1 when the counter wraps.
  - 64-bit wrap-around: `0xFFFF_FFFF_FFFF_FFFF` → 0.
- A write to `mtime` on the same edge as a tick takes priority: the written bytes are stored, and unwritten bytes keep their old value without increment. The tick counter is not reset by the write.
- `mtip_o` is registered: `mtip_o <= (mtime >= mtimecmp)` as an unsigned compare, using the current register values.
- `msip_o = msip[0]`, taken directly from the register.

## Timing
- Reset values:
  - `mtime=0`, tick counter = 0, `mtimecmp=64'hFFFF_FFFF_FFFF_FFFF`, `msip=0`
  - FSM in `IDLE`
  - `req_ready_o=1`, `resp_valid_o=0`, `resp_rdata_o=0`, `resp_err_o=0`, `mtip_o=0`, `msip_o=0`
- Latency: a request accepted at edge N has `resp_valid_o=1` in the cycle after edge N.
- `mtimecmp` written at edge N:
  - Compare uses the new value from edge N+1.
  - `mtip_o` reflects it after edge N+1, i.e. 1 cycle of lag.
- `msip` written at edge N: `msip_o` changes right after edge N.
- Reset asserted mid-response: the response is dropped and all state returns to reset values immediately. No response is issued after reset deasserts.
- `mtime` increments while the FSM is in `RESP`; the FSM state does not affect counting.

## Test plan
- Reset then idle 10 cycles with `TICK_DIV=1`:
  - Load of `BASE+0xBFF8` accepted in cycle 10 returns 10.
  - `mtip_o=0` and `msip_o=0` throughout.
- Store `mtimecmp=20` with `wstrb=0xFF` while `mtime=15`:
  - `mtip_o` rises on the edge where `mtime` becomes 20, plus 1 cycle of lag.
  - After a store `mtimecmp=0xFFFF_FFFF_FFFF_FFFF`, `mtip_o` falls 1 cycle after that write.
- Hold `resp_ready_i=0` for 5 cycles after a load:
  - `resp_valid_o` and `resp_rdata_o` stay stable and `req_ready_o=0`.
  - A new `req_valid_i` is not accepted until the cycle after the handshake.
- Store `0xAAAA_BBBB_0000_0000` to `mtime` with `wstrb=0xF0` on a tick edge, while `mtime=0x5`:
  - `mtime` becomes `0xAAAA_BBBB_0000_0005`, with no increment on that edge.
- Load `BASE+0x1000`: `resp_err_o=1`, `rdata=0`, and no register changes.
- Store `msip=1`: `msip_o=1` on the next cycle. Assert `reset` during the following `RESP`: `resp_valid_o=0` and `msip_o=0` immediately.
